// File: rtl/cx_slot_sched_if.sv
// Signal bundle between the command-slot scheduler and its host/device side.
// slave = scheduler view, master = host/device view.
interface cx_slot_sched_if #(
   parameter int C_NUM_SLOTS = 4,
   parameter int C_SLOT_W    = 2
);
   logic [C_NUM_SLOTS-1:0] slot_issue;
   logic                   dma_done;
   logic                   cxfifo_irq;
   logic [3:0]             error_code;
   logic                   dma_req;
   logic [C_SLOT_W-1:0]    cur_slot;
   logic                   cxfifo_ok;
   logic                   cxfifo_ack;
   logic [C_NUM_SLOTS-1:0] slot_pending;
   logic [C_NUM_SLOTS-1:0] slot_done;
   logic [C_NUM_SLOTS-1:0] slot_err;
   logic [3:0]             slot_err_code;
   logic                   busy;

   modport master (
      output slot_issue, dma_done, cxfifo_irq, error_code,
      input  dma_req, cur_slot, cxfifo_ok, cxfifo_ack, slot_pending,
             slot_done, slot_err, slot_err_code, busy
   );

   modport slave (
      input  slot_issue, dma_done, cxfifo_irq, error_code,
      output dma_req, cur_slot, cxfifo_ok, cxfifo_ack, slot_pending,
             slot_done, slot_err, slot_err_code, busy
   );
endinterface

// File: rtl/cx_slot_sched.sv
// Round-robin command-slot scheduler: one in-flight slot, DMA data phase, level IRQ completion, bounded retry.
// Optional per-command watchdog enabled by defining CX_SLOT_SCHED_TIMEOUT_EN.
module cx_slot_sched #(
   parameter int C_NUM_SLOTS = 4,
   parameter int C_SLOT_W    = 2,
   parameter int C_TIMEOUT   = 65535,
   parameter int C_MAX_RETRY = 2
) (
   input  logic           sys_clk,
   input  logic           sys_rst_n,
   cx_slot_sched_if.slave bus
);
   if (C_NUM_SLOTS != (1 << C_SLOT_W) || C_NUM_SLOTS < 2 || C_NUM_SLOTS > 8 ||
       C_TIMEOUT < 1 || C_TIMEOUT > 65535 || C_MAX_RETRY < 0 || C_MAX_RETRY > 3) begin : g_bad_cfg
      $error("cx_slot_sched: illegal parameter set");
   end

   typedef enum logic [2:0] {IDLE, XFER, WAIT_IRQ, RESP, DRAIN} state_e;

   state_e                      state_q, state_d;
   logic [C_SLOT_W-1:0]         cur_slot_q, cur_slot_d;
   logic [C_SLOT_W-1:0]         last_slot_q, last_slot_d;
   logic [C_NUM_SLOTS-1:0]      pending_q, pending_d;
   logic [C_NUM_SLOTS-1:0][1:0] retry_q, retry_d;
   logic [3:0]                  code_q, code_d;
   logic [3:0]                  err_code_q, err_code_d;

   logic                        pick_vld;
   logic [C_SLOT_W-1:0]         pick_slot;
   logic [C_SLOT_W-1:0]         rr_idx;
   logic [C_NUM_SLOTS-1:0]      cur_oh;
   logic [C_NUM_SLOTS-1:0]      clr_mask;
   logic                        retry_spent;
   logic                        in_resp;
   logic                        resp_err;
   logic                        resp_final;

`ifdef CX_SLOT_SCHED_TIMEOUT_EN
   logic [15:0]                 tmo_cnt_q, tmo_cnt_d;
   logic                        to_err_q, to_err_d;
`endif

   // Search downward so the nearest pending slot after last_slot wins.
   always_comb begin
      pick_vld  = 1'b0;
      pick_slot = '0;
      rr_idx    = '0;
      for (int i = C_NUM_SLOTS; i >= 1; i--) begin
         rr_idx = last_slot_q + C_SLOT_W'(i);
         if (pending_q[rr_idx]) begin
            pick_vld  = 1'b1;
            pick_slot = rr_idx;
         end
      end
   end

   always_comb begin
      cur_oh             = '0;
      cur_oh[cur_slot_q] = 1'b1;
   end

   assign retry_spent = retry_q[cur_slot_q] >= 2'(C_MAX_RETRY);
   assign in_resp     = (state_q == RESP);
   assign resp_err    = (code_q != 4'h0);
   assign resp_final  = in_resp && resp_err && retry_spent;

   always_comb begin
      state_d     = state_q;
      cur_slot_d  = cur_slot_q;
      last_slot_d = last_slot_q;
      retry_d     = retry_q;
      code_d      = code_q;
      err_code_d  = err_code_q;
      clr_mask    = '0;
`ifdef CX_SLOT_SCHED_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
      to_err_d    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d     = XFER;
               cur_slot_d  = pick_slot;
               last_slot_d = pick_slot;
`ifdef CX_SLOT_SCHED_TIMEOUT_EN
               tmo_cnt_d   = '0;
`endif
            end
         end
         XFER: begin
            if (bus.dma_done) state_d = WAIT_IRQ;
         end
         WAIT_IRQ: begin
            if (bus.cxfifo_irq) begin
               state_d = RESP;
               code_d  = bus.error_code;
               // Load the final-error code now so it is valid alongside the slot_err pulse.
               if (bus.error_code != 4'h0 && retry_spent) err_code_d = bus.error_code;
            end
         end
         RESP: begin
            state_d = DRAIN;
            if (resp_err && !retry_spent) begin
               retry_d[cur_slot_q] = retry_q[cur_slot_q] + 2'd1;
            end else begin
               clr_mask            = cur_oh;
               retry_d[cur_slot_q] = 2'd0;
            end
         end
         DRAIN: begin
            if (!bus.cxfifo_irq) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
`ifdef CX_SLOT_SCHED_TIMEOUT_EN
      if (state_q == XFER || state_q == WAIT_IRQ) begin
         if (tmo_cnt_q == 16'(C_TIMEOUT - 1)) begin
            state_d             = IDLE;
            clr_mask            = cur_oh;
            retry_d[cur_slot_q] = 2'd0;
            err_code_d          = 4'hF;
            to_err_d            = 1'b1;
         end else begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
         end
      end
`endif
      // Issue is ORed after the clear so a coinciding re-issue keeps the slot pending.
      pending_d = (pending_q & ~clr_mask) | bus.slot_issue;
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q     <= IDLE;
         cur_slot_q  <= '0;
         last_slot_q <= C_SLOT_W'(C_NUM_SLOTS - 1);
         pending_q   <= '0;
         retry_q     <= '0;
         code_q      <= '0;
         err_code_q  <= '0;
`ifdef CX_SLOT_SCHED_TIMEOUT_EN
         tmo_cnt_q   <= '0;
         to_err_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cur_slot_q  <= cur_slot_d;
         last_slot_q <= last_slot_d;
         pending_q   <= pending_d;
         retry_q     <= retry_d;
         code_q      <= code_d;
         err_code_q  <= err_code_d;
`ifdef CX_SLOT_SCHED_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
         to_err_q    <= to_err_d;
`endif
      end
   end

   assign bus.dma_req       = (state_q == XFER);
   assign bus.cur_slot      = cur_slot_q;
   assign bus.busy          = (state_q != IDLE);
   assign bus.slot_pending  = pending_q;
   assign bus.slot_err_code = err_code_q;
   assign bus.cxfifo_ok     = in_resp && !resp_err;
   assign bus.cxfifo_ack    = in_resp && resp_err;
   assign bus.slot_done     = (in_resp && !resp_err) ? cur_oh : '0;
`ifdef CX_SLOT_SCHED_TIMEOUT_EN
   // Timeout error pulses the cycle after the abort; cur_slot still names the aborted slot.
   assign bus.slot_err      = (resp_final || to_err_q) ? cur_oh : '0;
`else
   assign bus.slot_err      = resp_final ? cur_oh : '0;
`endif
endmodule

// File: doc/cx_slot_sched.md
CX_SLOT_SCHED -- requirements
Module: cx_slot_sched

Interface
REQ-001: Parameters (name, default, meaning), one per line:
  C_NUM_SLOTS, 4, number of command slots; power of two, 2..8
  C_SLOT_W, 2, log2(C_NUM_SLOTS)
  C_TIMEOUT, 65535, per-command cycle limit; 16-bit
  C_MAX_RETRY, 2, retries after device error; 0..3
REQ-002: Ports (name, direction, width, meaning), one per line:
  sys_clk  in  1  sole clock
  sys_rst_n  in  1  synchronous reset, active low
  slot_issue  in  C_NUM_SLOTS  one-cycle pulse per bit; marks slot pending
  dma_done  in  1  one-cycle pulse; data phase of in-flight command complete
  cxfifo_irq  in  1  level; completion status valid
  error_code  in  4  completion status; 0 = success
  dma_req  out  1  data phase request for in-flight slot
  cur_slot  out  C_SLOT_W  in-flight slot index
  cxfifo_ok  out  1  one-cycle pulse; success completion consumed
  cxfifo_ack  out  1  one-cycle pulse; error completion consumed
  slot_pending  out  C_NUM_SLOTS  pending bitmap
  slot_done  out  C_NUM_SLOTS  one-cycle pulse; slot finished OK
  slot_err  out  C_NUM_SLOTS  one-cycle pulse; slot failed finally
  slot_err_code  out  4  code of last slot_err; held until next slot_err
  busy  out  1  high in any state other than IDLE

Function
REQ-003: The FSM SHALL have states IDLE, XFER, WAIT_IRQ, RESP and DRAIN.
REQ-004: In IDLE with slot_pending nonzero, the FSM SHALL select the first pending slot searching round-robin from last_slot+1 modulo C_NUM_SLOTS, load cur_slot and last_slot, and enter XFER on the next edge.
REQ-005: dma_req SHALL be high exactly while in XFER; a dma_done pulse in XFER SHALL move the FSM to WAIT_IRQ; dma_done outside XFER SHALL be ignored.
REQ-006: In WAIT_IRQ, cxfifo_irq high SHALL move the FSM to RESP; error_code SHALL be sampled on that same edge.
REQ-007: In RESP (one cycle), for sampled code 0 the block SHALL pulse cxfifo_ok and slot_done[cur_slot], and SHALL clear the pending bit and retry count of cur_slot.
REQ-008: In RESP, for a nonzero code the block SHALL pulse cxfifo_ack; if retry_cnt[cur_slot] < C_MAX_RETRY, it SHALL increment retry_cnt and keep the slot pending.
REQ-009: Otherwise, for a nonzero code, it SHALL pulse slot_err[cur_slot], load slot_err_code, and clear the pending bit and retry count.
REQ-010: RESP SHALL go to DRAIN; DRAIN SHALL return to IDLE on the first cycle cxfifo_irq is low, so that one level completion is never counted twice.
REQ-011: slot_issue on a non-pending slot SHALL set its pending bit on the next edge; slot_issue on an already-pending slot, including the in-flight slot, SHALL be ignored.
REQ-012: slot_issue coinciding with the RESP clear of the same slot SHALL leave the bit set (set wins) with retry count 0.
REQ-013: Retry SHALL be round-robin fair: a retried slot SHALL be re-selected only after the other pending slots later in rotation order.
REQ-014: cxfifo_ok, cxfifo_ack, slot_done and slot_err SHALL each be at most one cycle wide per command; ok and ack SHALL never be high together.

Reset
REQ-015: sys_rst_n low at a sys_clk edge SHALL force IDLE and clear all pending bits and retry counts.
REQ-016: The same reset edge SHALL zero cur_slot and all outputs, including slot_err_code.
REQ-017: Reset SHALL set last_slot = C_NUM_SLOTS-1, so slot 0 is selected first after reset.
REQ-018: Reset mid-command SHALL drop dma_req on the next edge and produce no ok, ack, done or err pulse.

Configuration
REQ-019: With macro CX_SLOT_SCHED_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entry to XFER and count each cycle in XFER and WAIT_IRQ.
REQ-020: With CX_SLOT_SCHED_TIMEOUT_EN defined, reaching C_TIMEOUT SHALL abort to IDLE, pulse slot_err[cur_slot], set slot_err_code=4'hF, clear pending, emit no cxfifo_ok or cxfifo_ack, and apply no retry.
REQ-021: Without CX_SLOT_SCHED_TIMEOUT_EN, no counter SHALL exist, XFER and WAIT_IRQ SHALL wait indefinitely, C_TIMEOUT SHALL be ignored, and code 4'hF SHALL never originate in this block.

Verification
REQ-022: slot_issue=4'b0101 after reset, each with dma_done then irq and code 0 -> slot 0 then slot 2 served; two cxfifo_ok pulses; slot_done 4'b0001 then 4'b0100.
REQ-023: slot 1 alone, code 4'h3 on every attempt, C_MAX_RETRY=2 -> three XFER phases, three cxfifo_ack pulses, then slot_err=4'b0010 with slot_err_code=4'h3.
REQ-024: slots 0 and 1 pending, slot 0 fails once -> service order 0,1,0; slot 0 completes with cxfifo_ok.
REQ-025: cxfifo_irq held high 10 cycles after RESP -> exactly one completion; FSM stays in DRAIN until irq low; next slot then starts.
REQ-026: TIMEOUT_EN, C_TIMEOUT=100, no dma_done -> slot_err pulse with code 4'hF; dma_req low 100 cycles after XFER entry.
REQ-027: sys_rst_n low for one cycle during XFER -> dma_req=0, slot_pending=0 and busy=0 next cycle; no completion pulses.
